// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the parametrised MIPS register file.
package regfile_pkg;
  localparam int DATA_W_DEF    = 4;
  localparam int ADDR_W_DEF    = 2;
  localparam int CNT_W_DEF     = 8;
  localparam int LED_ALIVE_BIT = 7;

  // Caller zero-extends data to 32 bits, so narrow data comes back zero-padded.
  function automatic logic [6:0] led_pack(input logic [31:0] data);
    return data[6:0];
  endfunction
endpackage

// File: rtl/regfile_wr_arbiter.sv
// Decides which of the two write ports take effect this cycle.
module regfile_wr_arbiter
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 0
) (
  input  logic              reset,
  input  logic              wr_en_a,
  input  logic [ADDR_W-1:0] wr_addr_a,
  input  logic              wr_en_b,
  input  logic [ADDR_W-1:0] wr_addr_b,
  output logic              accept_a,
  output logic              accept_b,
  output logic              collision,
  output logic [1:0]        accept_cnt
);
  logic valid_b;

  always_comb begin
    accept_a   = wr_en_a && !reset && !((ZERO_REG != 0) && (wr_addr_a == '0));
    valid_b    = wr_en_b && !reset && !((ZERO_REG != 0) && (wr_addr_b == '0));
    // Port A wins a same-address collision; B is then not counted.
    collision  = accept_a && valid_b && (wr_addr_a == wr_addr_b);
    accept_b   = valid_b && !collision;
    accept_cnt = {1'b0, accept_a} + {1'b0, accept_b};
  end
endmodule

// File: rtl/regfile_param.sv
// Two-read / two-write register file with optional zero register, bypass and debug outputs.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              wr_en_a,
  input  logic [ADDR_W-1:0] wr_addr_a,
  input  logic [DATA_W-1:0] wr_data_a,
  input  logic              wr_en_b,
  input  logic [ADDR_W-1:0] wr_addr_b,
  input  logic [DATA_W-1:0] wr_data_b,
  output logic [7:0]        led,
  output logic [CNT_W-1:0]  wr_count
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic                          accept_a, accept_b, collision;
  logic [1:0]                    accept_cnt;
  logic [DEPTH-1:0][DATA_W-1:0]  mem_q, mem_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [CNT_W:0]                cnt_sum;
  logic                          alive_q, alive_d;
  logic [6:0]                    led_data_q, led_data_d;
  logic [1:0][ADDR_W-1:0]        rd_addr_v;
  logic [1:0][DATA_W-1:0]        rd_v;

  regfile_wr_arbiter #(.ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_arb (
    .reset      (reset),
    .wr_en_a    (wr_en_a),
    .wr_addr_a  (wr_addr_a),
    .wr_en_b    (wr_en_b),
    .wr_addr_b  (wr_addr_b),
    .accept_a   (accept_a),
    .accept_b   (accept_b),
    .collision  (collision),
    .accept_cnt (accept_cnt)
  );

  // Accept flags already include reset, so bypass is naturally off during reset.
  always_comb begin
    rd_addr_v[0] = rd_addr1;
    rd_addr_v[1] = rd_addr2;
    rd_v         = '0;
    for (int p = 0; p < 2; p++) begin
      rd_v[p] = mem_q[rd_addr_v[p]];
      if (BYPASS != 0) begin
        if (accept_b && (wr_addr_b == rd_addr_v[p])) rd_v[p] = wr_data_b;
        if (accept_a && (wr_addr_a == rd_addr_v[p])) rd_v[p] = wr_data_a;
      end
      if ((ZERO_REG != 0) && (rd_addr_v[p] == '0)) rd_v[p] = '0;
    end
  end

  assign rd_data1 = rd_v[0];
  assign rd_data2 = rd_v[1];

  always_comb begin
    mem_d      = mem_q;
    led_data_d = led_data_q;
    alive_d    = 1'b1;
    cnt_sum    = {1'b0, cnt_q} + (CNT_W+1)'(accept_cnt);
    cnt_d      = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
    if (accept_b) mem_d[wr_addr_b] = wr_data_b;
    if (accept_a) mem_d[wr_addr_a] = wr_data_a;
    if (accept_a)      led_data_d = led_pack(32'(wr_data_a));
    else if (accept_b) led_data_d = led_pack(32'(wr_data_b));
    if (reset) begin
      mem_d      = '0;
      led_data_d = '0;
      alive_d    = 1'b0;
      cnt_d      = '0;
    end
  end

  always_ff @(posedge clk) begin
    mem_q      <= mem_d;
    cnt_q      <= cnt_d;
    alive_q    <= alive_d;
    led_data_q <= led_data_d;
  end

  assign led      = {alive_q, led_data_q};
  assign wr_count = cnt_q;

  logic unused_collision;
  assign unused_collision = collision;
endmodule

// File: tb/tb_regfile_param.sv
// Drives a default (bypass, 8-bit counter) and a zero-reg/no-bypass/2-bit-counter file in lockstep.
module tb_regfile_param;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] rd_addr1 = '0, rd_addr2 = '0;
  logic       wr_en_a = 1'b0, wr_en_b = 1'b0;
  logic [1:0] wr_addr_a = '0, wr_addr_b = '0;
  logic [3:0] wr_data_a = '0, wr_data_b = '0;

  logic [3:0] rd1_a, rd2_a, rd1_b, rd2_b;
  logic [7:0] led_a, led_b, cnt_a;
  logic [1:0] cnt_b;

  always #5 clk = ~clk;

  regfile_param #(.DATA_W(4), .ADDR_W(2), .ZERO_REG(0), .BYPASS(1), .CNT_W(8)) u_a (
    .clk(clk), .reset(reset), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd1_a), .rd_data2(rd2_a),
    .wr_en_a(wr_en_a), .wr_addr_a(wr_addr_a), .wr_data_a(wr_data_a),
    .wr_en_b(wr_en_b), .wr_addr_b(wr_addr_b), .wr_data_b(wr_data_b),
    .led(led_a), .wr_count(cnt_a));

  regfile_param #(.DATA_W(4), .ADDR_W(2), .ZERO_REG(1), .BYPASS(0), .CNT_W(2)) u_b (
    .clk(clk), .reset(reset), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd1_b), .rd_data2(rd2_b),
    .wr_en_a(wr_en_a), .wr_addr_a(wr_addr_a), .wr_data_a(wr_data_a),
    .wr_en_b(wr_en_b), .wr_addr_b(wr_addr_b), .wr_data_b(wr_data_b),
    .led(led_b), .wr_count(cnt_b));

  typedef struct {
    string      tag;
    logic [7:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference state per configuration: index 0 = u_a, 1 = u_b.
  logic [3:0] m_mem [2][4];
  int         m_cnt [2];
  logic [7:0] m_led [2];
  int         zr    [2] = '{0, 1};
  int         byp   [2] = '{1, 0};
  int         cmax  [2] = '{255, 3};

  function automatic bit acc_a(int c);
    return wr_en_a && !reset && !(zr[c] == 1 && wr_addr_a == 2'd0);
  endfunction

  function automatic bit acc_b(int c);
    bit vb;
    vb = wr_en_b && !reset && !(zr[c] == 1 && wr_addr_b == 2'd0);
    return vb && !(acc_a(c) && wr_addr_a == wr_addr_b);
  endfunction

  function automatic logic [3:0] mread(int c, logic [1:0] addr);
    if (zr[c] == 1 && addr == 2'd0)               return 4'h0;
    if (byp[c] == 1 && acc_a(c) && wr_addr_a == addr) return wr_data_a;
    if (byp[c] == 1 && acc_b(c) && wr_addr_b == addr) return wr_data_b;
    return m_mem[c][addr];
  endfunction

  task automatic push(input string tag, input logic [7:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [7:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: got %h expected <entry>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s: got %h expected %h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic model_edge();
    for (int c = 0; c < 2; c++) begin
      bit aa, ab;
      aa = acc_a(c);
      ab = acc_b(c);
      if (reset) begin
        for (int i = 0; i < 4; i++) m_mem[c][i] = 4'h0;
        m_cnt[c] = 0;
        m_led[c] = 8'h00;
      end else begin
        if (ab) m_mem[c][wr_addr_b] = wr_data_b;
        if (aa) m_mem[c][wr_addr_a] = wr_data_a;
        m_cnt[c] = m_cnt[c] + int'(aa) + int'(ab);
        if (m_cnt[c] > cmax[c]) m_cnt[c] = cmax[c];
        if (aa)      m_led[c][6:0] = {3'b000, wr_data_a};
        else if (ab) m_led[c][6:0] = {3'b000, wr_data_b};
        m_led[c][7] = 1'b1;
      end
    end
  endtask

  // One cycle: drive, check combinational reads before the edge, then debug outputs after it.
  task automatic step(input logic [1:0] ra1, input logic [1:0] ra2,
                      input logic wa, input logic [1:0] aa, input logic [3:0] da,
                      input logic wb, input logic [1:0] ab, input logic [3:0] db,
                      input logic rst);
    @(negedge clk);
    rd_addr1 = ra1; rd_addr2 = ra2;
    wr_en_a = wa; wr_addr_a = aa; wr_data_a = da;
    wr_en_b = wb; wr_addr_b = ab; wr_data_b = db;
    reset = rst;
    #1;
    push("a_rd1", {4'h0, mread(0, ra1)});
    push("a_rd2", {4'h0, mread(0, ra2)});
    push("b_rd1", {4'h0, mread(1, ra1)});
    push("b_rd2", {4'h0, mread(1, ra2)});
    chk({4'h0, rd1_a}); chk({4'h0, rd2_a});
    chk({4'h0, rd1_b}); chk({4'h0, rd2_b});
    @(posedge clk);
    model_edge();
    #1;
    push("a_led", m_led[0]);
    push("a_cnt", 8'(m_cnt[0]));
    push("b_led", m_led[1]);
    push("b_cnt", 8'(m_cnt[1]));
    chk(led_a); chk(cnt_a);
    chk(led_b); chk({6'h0, cnt_b});
  endtask

  initial begin
    reset = 1'b1;
    repeat (2) @(posedge clk);
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < 4; i++) m_mem[c][i] = 4'h0;
      m_cnt[c] = 0;
      m_led[c] = 8'h00;
    end
    // Reset held: every address reads zero, debug outputs zero.
    step(2'd0, 2'd1, 0, 2'd0, 4'h0, 0, 2'd0, 4'h0, 1);
    step(2'd2, 2'd3, 0, 2'd0, 4'h0, 0, 2'd0, 4'h0, 1);
    // First edge out of reset sets the alive bit.
    step(2'd0, 2'd0, 0, 2'd0, 4'h0, 0, 2'd0, 4'h0, 0);
    // Single write; bypassed in u_a, visible next cycle in u_b.
    step(2'd2, 2'd2, 1, 2'd2, 4'hB, 0, 2'd0, 4'h0, 0);
    step(2'd2, 2'd0, 0, 2'd0, 4'h0, 0, 2'd0, 4'h0, 0);
    step(2'd0, 2'd1, 1, 2'd1, 4'h5, 0, 2'd0, 4'h0, 0);
    // Same-address dual write: A wins, counts once.
    step(2'd3, 2'd3, 1, 2'd3, 4'h1, 1, 2'd3, 4'h7, 0);
    step(2'd3, 2'd1, 0, 2'd0, 4'h0, 0, 2'd0, 4'h0, 0);
    // Dual write to 0/1: u_b rejects the A write to its zero register.
    step(2'd0, 2'd1, 1, 2'd0, 4'hC, 1, 2'd1, 4'h6, 0);
    step(2'd0, 2'd1, 0, 2'd0, 4'h0, 0, 2'd0, 4'h0, 0);
    // Zero-register write only.
    step(2'd0, 2'd0, 1, 2'd0, 4'hF, 0, 2'd0, 4'h0, 0);
    step(2'd0, 2'd3, 0, 2'd0, 4'h0, 0, 2'd0, 4'h0, 0);
    // B alone writing, read through bypass on u_a.
    step(2'd2, 2'd3, 0, 2'd0, 4'h0, 1, 2'd2, 4'hD, 0);
    // Saturation of the 2-bit counter.
    for (int i = 0; i < 5; i++)
      step(2'd3, 2'd3, 1, 2'd3, 4'(i + 2), 0, 2'd0, 4'h0, 0);
    // Reset on the same edge as a write: write lost, no bypass.
    step(2'd2, 2'd2, 1, 2'd2, 4'h9, 0, 2'd0, 4'h0, 1);
    step(2'd2, 2'd3, 0, 2'd0, 4'h0, 0, 2'd0, 4'h0, 0);
    // Mixed random traffic.
    for (int i = 0; i < 40; i++)
      step(2'($urandom_range(3)), 2'($urandom_range(3)),
           1'($urandom_range(1)), 2'($urandom_range(3)), 4'($urandom_range(15)),
           1'($urandom_range(1)), 2'($urandom_range(3)), 4'($urandom_range(15)),
           ($urandom_range(15) == 0));
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
- Parametrised register file: DEPTH = 2**ADDR_W entries of DATA_W bits, two asynchronous read ports, two synchronous write ports.
- Optional hardwired-zero register 0 and optional write-to-read bypass.
- Carries a board debug path (led, accepted-write counter) to the top level.
- Sits in the MIPS datapath between decode and ALU; replaces the fixed 4x4-bit single-write file.

Parameters:
DATA_W, 4, register width in bits (1..32)
ADDR_W, 2, address width; DEPTH = 2**ADDR_W
ZERO_REG, 0, 1 = register 0 reads as zero and ignores writes
BYPASS, 1, 1 = a read of an address being written this cycle returns the new data
CNT_W, 8, width of the accepted-write counter

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
rd_addr1  in  ADDR_W  read port 1 address
rd_addr2  in  ADDR_W  read port 2 address
rd_data1  out  DATA_W  read port 1 data, combinational
rd_data2  out  DATA_W  read port 2 data, combinational
wr_en_a  in  1  write port A enable (priority port)
wr_addr_a  in  ADDR_W  write port A address
wr_data_a  in  DATA_W  write port A data
wr_en_b  in  1  write port B enable
wr_addr_b  in  ADDR_W  write port B address
wr_data_b  in  DATA_W  write port B data
led  out  8  debug: led[7] alive flag, led[6:0] last accepted write data
wr_count  out  CNT_W  saturating count of accepted writes

Behaviour:
- Reset: on a rising edge with reset=1, all entries, led and wr_count go to 0. Writes in that cycle are discarded.
- Reset mid-operation: writes in flight are lost. While reset=1, bypass is disabled, so reads return stored values.
- Write acceptance:
  - A port write is accepted when its wr_en=1, reset=0, and not (ZERO_REG=1 and address=0).
  - An accepted write updates the entry at the next rising edge (latency 1).
- Write collision: both ports accepted with the same address -> port A data is stored, port B is dropped and counts as not accepted.
- Reads:
  - rd_dataN = entry[rd_addrN] combinationally.
  - With ZERO_REG=1, address 0 always reads 0.
- Bypass (BYPASS=1, reset=0):
  - If rd_addrN matches an accepted write address this cycle, rd_dataN returns that write's data.
  - If both ports write the matching address, port A data is returned.
  - With BYPASS=0, the new value is visible the cycle after the edge.
- wr_count:
  - Increments by the number of accepted writes this cycle: 0, 1 or 2. A collision counts as 1.
  - Saturates at 2**CNT_W-1; never wraps.
- led[7]: set to 1 on the first rising edge with reset=0; held until reset.
- led[6:0] update on every edge with any accepted write:
  - Source is port A's data if A is accepted, else port B's.
  - The data is zero-extended to 7 bits if DATA_W<7, or takes its low 7 bits if DATA_W>7.
  - led[6:0] hold otherwise.
- Widths: no arithmetic on data; addresses are always in range by construction (DEPTH = 2**ADDR_W).

Decomposition:
- Shared package regfile_pkg:
  - Default DATA_W, ADDR_W and CNT_W constants.
  - LED_ALIVE_BIT = 7.
  - Function led_pack(data) for zero-extend/truncate to 7 bits.
- One natural sub-module: regfile_wr_arbiter (combinational). It produces the accept_a / accept_b flags, the collision flag, and the accepted count (0..2). It is shared by the storage, bypass and counter logic.

Test Plan:
- Reset then read: reset=1 for 2 cycles, then read all addresses -> rd_data1/2 = 0, led = 8'h00, wr_count = 0; one cycle after deassert, led = 8'h80.
- Single write, BYPASS=0: write A addr 2 data 4'hB -> rd_data1 (addr 2) = 0 in the same cycle and 4'hB after the edge; led = 8'h8B, wr_count = 1.
- Bypass, BYPASS=1: write A addr 1 data 4'h5 with rd_addr2 = 1 in the same cycle -> rd_data2 = 4'h5 before the edge.
- Dual write, same address: A = (3, 4'h1), B = (3, 4'h7) -> entry 3 = 4'h1, wr_count +1, led[6:0] = 7'h01. Dual write to different addresses 0/1 -> both stored, wr_count +2.
- ZERO_REG=1: write A addr 0 data 4'hF -> rd_data1 (addr 0) = 0; wr_count and led unchanged.
- Saturation and mid-op reset:
  - With CNT_W=2, issue 5 single writes -> wr_count sticks at 3.
  - Assert reset on the same edge as a write of 4'h9 to addr 2 -> entry 2 = 0 and wr_count = 0.
